// File: rtl/sifh_pkg.sv
// -----------------------------------------------------------------------------
// sifh_pkg
// Shared definitions for the TDC stream serializer that feeds hisBuilderFSM.
//   NO_HIT        : all-ones "no photon" marker; users take the low NP bits
//   ser_state_t   : serializer FSM states (IDLE, SHIFT)
//   *_DEF         : default timestamp width, pixel count and acquisitions/frame
// -----------------------------------------------------------------------------
package sifh_pkg;

    localparam int NP_DEF        = 10;
    localparam int PIXEL_NUM_DEF = 6;
    localparam int ACQ_NUM_DEF   = 2;

    // Wide enough for any sensible timestamp width; sliced down to NP bits
    localparam logic [31:0] NO_HIT = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/tdc_stream_serializer.sv
// -----------------------------------------------------------------------------
// tdc_stream_serializer
// Captures one acquisition (one laser shot) of per-pixel TDC timestamps in
// parallel and streams it to the histogram builder, one pixel per clock,
// pixel 0 first. Counts acquisitions and flags the last word of each frame.
//
// Ports
//   clk        : system clock, rising edge
//   res        : asynchronous active-low reset
//   acqValid   : new acquisition present on tdcData/tdcHit
//   tdcData    : packed timestamps, pixel p at [p*NP +: NP]
//   tdcHit     : per-pixel photon flag
//   acqReady   : acqValid is accepted this cycle
//   wrEn       : data valid to histogram builder
//   data       : serialized timestamp (NO_HIT for pixels without a photon)
//   pixIdx     : pixel index of the current data word
//   frameDone  : pulse with the last word of the last acquisition of a frame
//   overrun    : pulse the cycle after an acqValid was dropped
//   overrunCnt : saturating count of dropped acquisitions
//                (only when SER_OVERRUN_CNT_EN is defined)
// -----------------------------------------------------------------------------
module tdc_stream_serializer
    import sifh_pkg::*;
#(
    parameter int NP        = NP_DEF,
    parameter int PIXEL_NUM = PIXEL_NUM_DEF,
    parameter int ACQ_NUM   = ACQ_NUM_DEF,
    localparam int IDX_W    = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
)(
    input  logic                    clk,
    input  logic                    res,
    input  logic                    acqValid,
    input  logic [PIXEL_NUM*NP-1:0] tdcData,
    input  logic [PIXEL_NUM-1:0]    tdcHit,
    output logic                    acqReady,
    output logic                    wrEn,
    output logic [NP-1:0]           data,
    output logic [IDX_W-1:0]        pixIdx,
    output logic                    frameDone,
    output logic                    overrun
`ifdef SER_OVERRUN_CNT_EN
    ,
    output logic [15:0]             overrunCnt
`endif
);

    localparam int               CNT_W    = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_NUM - 1);
    localparam logic [CNT_W-1:0] LAST_ACQ = CNT_W'(ACQ_NUM - 1);
    localparam logic [NP-1:0]    NO_HIT_W = NO_HIT[NP-1:0];

    ser_state_t                state_q, state_d;
    logic [PIXEL_NUM*NP-1:0]   tsShadow_q, tsShadow_d;
    logic [PIXEL_NUM-1:0]      hitShadow_q, hitShadow_d;
    logic [CNT_W-1:0]          acqCnt_q, acqCnt_d;
    logic                      wrEn_q, wrEn_d;
    logic [NP-1:0]             data_q, data_d;
    logic [IDX_W-1:0]          pixIdx_q, pixIdx_d;
    logic                      frameDone_q, frameDone_d;
    logic                      overrun_q, overrun_d;

    logic                      accept;
    logic                      moreWords;
    logic                      emit;
    logic [IDX_W-1:0]          emitIdx;
    logic [NP-1:0]             emitTs;
    logic                      emitHit;

    // Ready while idle, and also while the last word of the current
    // acquisition is on the bus so consecutive shots stream without a gap.
    assign acqReady  = (state_q == IDLE) || (pixIdx_q == LAST_IDX);
    assign accept    = acqValid && acqReady;
    assign moreWords = (state_q == SHIFT) && (pixIdx_q != LAST_IDX);

    // State and datapath registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= IDLE;
            tsShadow_q  <= '0;
            hitShadow_q <= '0;
            acqCnt_q    <= '0;
            wrEn_q      <= 1'b0;
            data_q      <= '0;
            pixIdx_q    <= '0;
            frameDone_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tsShadow_q  <= tsShadow_d;
            hitShadow_q <= hitShadow_d;
            acqCnt_q    <= acqCnt_d;
            wrEn_q      <= wrEn_d;
            data_q      <= data_d;
            pixIdx_q    <= pixIdx_d;
            frameDone_q <= frameDone_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (!moreWords && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic. Pixel 0 of a newly accepted shot is taken
    // straight from the inputs so it is on the bus one cycle after accept;
    // later pixels come from the shadow copy.
    always_comb begin
        tsShadow_d  = tsShadow_q;
        hitShadow_d = hitShadow_q;
        acqCnt_d    = acqCnt_q;
        wrEn_d      = 1'b0;
        data_d      = '0;
        pixIdx_d    = '0;
        frameDone_d = 1'b0;
        overrun_d   = acqValid && !acqReady;
        emit        = 1'b0;
        emitIdx     = '0;
        emitTs      = '0;
        emitHit     = 1'b0;

        if (accept) begin
            tsShadow_d  = tdcData;
            hitShadow_d = tdcHit;
            emit        = 1'b1;
            emitIdx     = '0;
            emitTs      = tdcData[NP-1:0];
            emitHit     = tdcHit[0];
        end else if (moreWords) begin
            emit        = 1'b1;
            emitIdx     = pixIdx_q + 1'b1;
            emitTs      = tsShadow_q[emitIdx*NP +: NP];
            emitHit     = hitShadow_q[emitIdx];
        end

        if (emit) begin
            wrEn_d   = 1'b1;
            pixIdx_d = emitIdx;
            data_d   = emitHit ? emitTs : NO_HIT_W;
            // Acquisition bookkeeping happens on each shot's last word
            if (emitIdx == LAST_IDX) begin
                if (acqCnt_q == LAST_ACQ) begin
                    acqCnt_d    = '0;
                    frameDone_d = 1'b1;
                end else begin
                    acqCnt_d    = acqCnt_q + 1'b1;
                end
            end
        end
    end

    assign wrEn      = wrEn_q;
    assign data      = data_q;
    assign pixIdx    = pixIdx_q;
    assign frameDone = frameDone_q;
    assign overrun   = overrun_q;

`ifdef SER_OVERRUN_CNT_EN
    logic [15:0] overrunCnt_q, overrunCnt_d;

    // Dropped-acquisition counter, saturating, cleared only by reset
    always_comb begin
        overrunCnt_d = overrunCnt_q;
        if (acqValid && !acqReady && (overrunCnt_q != 16'hFFFF))
            overrunCnt_d = overrunCnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) overrunCnt_q <= '0;
        else      overrunCnt_q <= overrunCnt_d;
    end

    assign overrunCnt = overrunCnt_q;
`else
    // Build without the dropped-acquisition counter; overrun pulse only
`endif

endmodule

// File: tb/tb_tdc_stream_serializer.sv
// -----------------------------------------------------------------------------
// tb_tdc_stream_serializer
// Self-checking bench for tdc_stream_serializer (NP=10, PIXEL_NUM=6,
// ACQ_NUM=2). The reference model is a queue of expected output words: each
// accepted shot appends its six words, one word is popped per cycle, and the
// block is ready exactly when no word beyond the one on the bus is pending.
// -----------------------------------------------------------------------------
module tb_tdc_stream_serializer;

    localparam int NP  = 10;
    localparam int PN  = 6;
    localparam int ACQ = 2;

    typedef struct {
        int value;
        int idx;
        int frame;
    } word_t;

    logic             clk = 1'b0;
    logic             res;
    logic             acqValid;
    logic [PN*NP-1:0] tdcData;
    logic [PN-1:0]    tdcHit;
    logic             acqReady;
    logic             wrEn;
    logic [NP-1:0]    data;
    logic [2:0]       pixIdx;
    logic             frameDone;
    logic             overrun;
`ifdef SER_OVERRUN_CNT_EN
    logic [15:0]      overrunCnt;
`endif

    int    assertCount = 0;
    int    failCount   = 0;
    word_t expQ[$];
    int    acqTotal      = 0;
    int    expOverrun    = 0;
    int    expOverrunCnt = 0;

    tdc_stream_serializer #(.NP(NP), .PIXEL_NUM(PN), .ACQ_NUM(ACQ)) dut (
        .clk       (clk),
        .res       (res),
        .acqValid  (acqValid),
        .tdcData   (tdcData),
        .tdcHit    (tdcHit),
        .acqReady  (acqReady),
        .wrEn      (wrEn),
        .data      (data),
        .pixIdx    (pixIdx),
        .frameDone (frameDone),
        .overrun   (overrun)
`ifdef SER_OVERRUN_CNT_EN
        ,
        .overrunCnt(overrunCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Model: queue the six words a shot produces, frame flag on the last
    // word of every ACQ-th shot since reset.
    task automatic modelAccept(input logic [PN*NP-1:0] ts, input logic [PN-1:0] hit);
        word_t w;
        for (int k = 0; k < PN; k++) begin
            w.value = hit[k] ? int'(ts[k*NP +: NP]) : 1023;
            w.idx   = k;
            w.frame = ((k == PN-1) && ((acqTotal % ACQ) == ACQ-1)) ? 1 : 0;
            expQ.push_back(w);
        end
        acqTotal++;
    endtask

    task automatic modelReset();
        expQ.delete();
        acqTotal      = 0;
        expOverrun    = 0;
        expOverrunCnt = 0;
    endtask

    // Called at a falling edge: check what is on the bus, then drive the
    // inputs for the next rising edge and advance the model.
    task automatic applyStimulus(input bit valid, input logic [PN*NP-1:0] ts,
                                 input logic [PN-1:0] hit);
        word_t w;
        bit    ready;
        if (expQ.size() > 0) begin
            w = expQ.pop_front();
            checkOutput("wrEn", 32'(wrEn), 1);
            checkOutput("data", 32'(data), w.value);
            checkOutput("pixIdx", 32'(pixIdx), w.idx);
            checkOutput("frameDone", 32'(frameDone), w.frame);
        end else begin
            checkOutput("wrEnIdle", 32'(wrEn), 0);
            checkOutput("frameDoneIdle", 32'(frameDone), 0);
        end
        checkOutput("overrun", 32'(overrun), expOverrun);
`ifdef SER_OVERRUN_CNT_EN
        checkOutput("overrunCnt", 32'(overrunCnt), expOverrunCnt);
`endif
        ready = (expQ.size() == 0);
        checkOutput("acqReady", 32'(acqReady), 32'(ready));

        acqValid = valid;
        tdcData  = ts;
        tdcHit   = hit;
        expOverrun = (valid && !ready) ? 1 : 0;
        if (expOverrun == 1 && expOverrunCnt < 65535) expOverrunCnt++;
        if (valid && ready) modelAccept(ts, hit);
        @(negedge clk);
        acqValid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wrEn"}, 32'(wrEn), 0);
        checkOutput({tag, "_data"}, 32'(data), 0);
        checkOutput({tag, "_pixIdx"}, 32'(pixIdx), 0);
        checkOutput({tag, "_frameDone"}, 32'(frameDone), 0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 0);
        checkOutput({tag, "_acqReady"}, 32'(acqReady), 1);
    endtask

    logic [PN*NP-1:0] tsA;
    logic [PN*NP-1:0] tsB;
    logic [PN*NP-1:0] tsR;
    logic [PN-1:0]    hitR;

    initial begin
        tsA = {10'd7, 10'd90, 10'd200, 10'd1022, 10'd511, 10'd108};
        tsB = {10'd1, 10'd2, 10'd3, 10'd1023, 10'd5, 10'd6};

        // Reset held for three cycles with acqValid asserted
        res      = 1'b0;
        acqValid = 1'b1;
        tdcData  = tsA;
        tdcHit   = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkResetOutputs("reset");
        end
        res      = 1'b1;
        acqValid = 1'b0;
        modelReset();
        idleCycles(2);

        $display("[TB] single acquisition, all pixels hit");
        applyStimulus(1'b1, tsA, 6'b111111);
        idleCycles(8);

        $display("[TB] single acquisition, partial hits");
        applyStimulus(1'b1, tsA, 6'b101101);
        idleCycles(8);

        $display("[TB] back-to-back acquisitions");
        applyStimulus(1'b1, tsA, 6'b111111);
        idleCycles(5);
        applyStimulus(1'b1, tsB, 6'b111111);
        idleCycles(8);

        $display("[TB] overrun during word 2");
        applyStimulus(1'b1, tsB, 6'b110011);
        idleCycles(2);
        applyStimulus(1'b1, tsA, 6'b111111);
        idleCycles(8);

        $display("[TB] reset during word 3");
        applyStimulus(1'b1, tsA, 6'b111111);
        idleCycles(3);
        #2 res = 1'b0;
        #1 checkResetOutputs("midReset");
        modelReset();
        @(negedge clk);
        res = 1'b1;
        idleCycles(2);
        applyStimulus(1'b1, tsB, 6'b011111);
        idleCycles(5);
        applyStimulus(1'b1, tsA, 6'b111111);
        idleCycles(8);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < PN; k++)
                tsR[k*NP +: NP] = ($urandom_range(0, 7) == 0) ? 10'h3FF
                                                              : 10'($urandom);
            hitR = 6'($urandom);
            applyStimulus($urandom_range(0, 99) < 45, tsR, hitR);
        end
        idleCycles(8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
